// File: rtl/lfsr_checker_if.sv
// Bus between an LFSR stream source/monitor and lfsr_checker.
// LFSR_CHK_FIRST_ERR_EN adds the first-error position signals.
interface lfsr_checker_if #(
    parameter int unsigned ERR_W = 16
) ();
    logic             bit_in;
    logic             bit_valid;
    logic             res;
    logic             clr_err;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic             stuck;
`ifdef LFSR_CHK_FIRST_ERR_EN
    logic [15:0]      first_err_pos;
    logic             first_err_vld;

    modport master (
        output bit_in, bit_valid, res, clr_err,
        input  locked, err_pulse, err_cnt, stuck, first_err_pos, first_err_vld
    );

    modport slave (
        input  bit_in, bit_valid, res, clr_err,
        output locked, err_pulse, err_cnt, stuck, first_err_pos, first_err_vld
    );
`else
    modport master (
        output bit_in, bit_valid, res, clr_err,
        input  locked, err_pulse, err_cnt, stuck
    );

    modport slave (
        input  bit_in, bit_valid, res, clr_err,
        output locked, err_pulse, err_cnt, stuck
    );
`endif
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 10-bit XNOR LFSR stream (taps 10,7).
// Optional LFSR_CHK_FIRST_ERR_EN reports the bit position of the first error after lock.
module lfsr_checker #(
    parameter int unsigned LOCK_CNT = 16,
    parameter int unsigned LOSS_CNT = 4,
    parameter int unsigned ERR_W    = 16
) (
    input  logic          clk,
    input  logic          reset,
    lfsr_checker_if.slave chk
);
    localparam int unsigned SH_W    = 10;
    localparam int unsigned FILL_W  = 4;
    localparam int unsigned MATCH_W = 8;
    localparam int unsigned MISS_W  = 4;

    localparam logic [SH_W-1:0]    SH_ONES   = '1;
    localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(SH_W);
    localparam logic [MATCH_W-1:0] LOCK_LIM  = MATCH_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0]  LOSS_LIM  = MISS_W'(LOSS_CNT);
    localparam logic [ERR_W-1:0]   ERR_MAX   = '1;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [SH_W-1:0]    sh_q, sh_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic               err_pulse_q, err_pulse_d;
    logic               locked_q, locked_d;
    logic               stuck_q, stuck_d;

    logic pred_c;
    logic match_c;

    assign pred_c  = ~(sh_q[9] ^ sh_q[6]);
    assign match_c = (chk.bit_in == pred_c);

    // Next-state: resync, search/fill, locked free-run prediction, error counting
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        fill_d      = fill_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;

        if (chk.res) begin
            state_d     = ST_SEARCH;
            sh_d        = '0;
            fill_d      = '0;
            match_cnt_d = '0;
            miss_cnt_d  = '0;
        end else if (chk.bit_valid) begin
            unique case (state_q)
                ST_SEARCH: begin
                    sh_d = {sh_q[SH_W-2:0], chk.bit_in};
                    if (fill_q != FILL_FULL) begin
                        fill_d = fill_q + FILL_W'(1);
                    end else if (match_c && (sh_q != SH_ONES)) begin
                        if ((match_cnt_q + MATCH_W'(1)) == LOCK_LIM) begin
                            state_d     = ST_LOCKED;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + MATCH_W'(1);
                        end
                    end else begin
                        // Mismatch or XNOR lock-up pattern restarts the lock qualification
                        match_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    // Shadow runs on its own prediction so a channel error never propagates
                    sh_d = {sh_q[SH_W-2:0], pred_c};
                    if (match_c) begin
                        miss_cnt_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != ERR_MAX) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                        if ((miss_cnt_q + MISS_W'(1)) == LOSS_LIM) begin
                            state_d     = ST_SEARCH;
                            sh_d        = '0;
                            fill_d      = '0;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + MISS_W'(1);
                        end
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end

        if (chk.clr_err) begin
            err_cnt_d = '0;
        end

        locked_d = (state_d == ST_LOCKED);
        stuck_d  = (state_d == ST_SEARCH) && (fill_d == FILL_FULL) && (sh_d == SH_ONES);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SEARCH;
            sh_q        <= '0;
            fill_q      <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
            stuck_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            fill_q      <= fill_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= locked_d;
            stuck_q     <= stuck_d;
        end
    end

    assign chk.locked    = locked_q;
    assign chk.err_pulse = err_pulse_q;
    assign chk.err_cnt   = err_cnt_q;
    assign chk.stuck     = stuck_q;

`ifdef LFSR_CHK_FIRST_ERR_EN
    localparam int unsigned POS_W = 16;

    logic [POS_W-1:0] bits_since_lock_q, bits_since_lock_d;
    logic [POS_W-1:0] first_err_pos_q, first_err_pos_d;
    logic             first_err_vld_q, first_err_vld_d;
    logic             lock_entry_c;
    logic             locked_bit_c;

    assign lock_entry_c = (state_q == ST_SEARCH) && (state_d == ST_LOCKED);
    assign locked_bit_c = !chk.res && chk.bit_valid && (state_q == ST_LOCKED);

    // Position is the number of valid locked bits seen before the first mismatch
    always_comb begin
        bits_since_lock_d = bits_since_lock_q;
        first_err_pos_d   = first_err_pos_q;
        first_err_vld_d   = first_err_vld_q;

        if (lock_entry_c) begin
            bits_since_lock_d = '0;
        end else if (locked_bit_c && (bits_since_lock_q != '1)) begin
            bits_since_lock_d = bits_since_lock_q + POS_W'(1);
        end

        if (chk.res || chk.clr_err || lock_entry_c) begin
            first_err_pos_d = '0;
            first_err_vld_d = 1'b0;
        end else if (locked_bit_c && !match_c && !first_err_vld_q) begin
            first_err_pos_d = bits_since_lock_q;
            first_err_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bits_since_lock_q <= '0;
            first_err_pos_q   <= '0;
            first_err_vld_q   <= 1'b0;
        end else begin
            bits_since_lock_q <= bits_since_lock_d;
            first_err_pos_q   <= first_err_pos_d;
            first_err_vld_q   <= first_err_vld_d;
        end
    end

    assign chk.first_err_pos = first_err_pos_q;
    assign chk.first_err_vld = first_err_vld_q;
`endif
endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, single/burst errors, resync, stuck, saturation.
module tb_lfsr_checker;
    logic clk;
    logic reset;

    int checks;
    int errors;
    int pulse_cnt;
    bit locked_seen;
    logic [9:0] gen_q;

    lfsr_checker_if #(.ERR_W(16)) bus ();
    lfsr_checker_if #(.ERR_W(4))  bus4 ();

    assign bus4.bit_in    = bus.bit_in;
    assign bus4.bit_valid = bus.bit_valid;
    assign bus4.res       = bus.res;
    assign bus4.clr_err   = bus.clr_err;

    lfsr_checker #(.LOCK_CNT(16), .LOSS_CNT(4), .ERR_W(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .chk   (bus.slave)
    );

    lfsr_checker #(.LOCK_CNT(16), .LOSS_CNT(4), .ERR_W(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .chk   (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic b, input logic v, input logic r, input logic c);
        @(negedge clk);
        bus.bit_in    = b;
        bus.bit_valid = v;
        bus.res       = r;
        bus.clr_err   = c;
        @(posedge clk);
        #1;
        if (bus.err_pulse) pulse_cnt++;
        if (bus.locked) locked_seen = 1'b1;
    endtask

    task automatic gen_bit(input logic inv, input logic clr);
        gen_q = {gen_q[8:0], ~(gen_q[9] ^ gen_q[6])};
        cycle(gen_q[0] ^ inv, 1'b1, 1'b0, clr);
    endtask

    task automatic gen_n(input int n);
        for (int i = 0; i < n; i++) gen_bit(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        pulse_cnt     = 0;
        locked_seen   = 1'b0;
        gen_q         = 10'h001;
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        bus.res       = 1'b0;
        bus.clr_err   = 1'b0;
        do_reset();

        check("rst_locked", 32'(bus.locked), 32'd0);
        check("rst_pulse",  32'(bus.err_pulse), 32'd0);
        check("rst_errcnt", 32'(bus.err_cnt), 32'd0);
        check("rst_stuck",  32'(bus.stuck), 32'd0);

        // Acquisition: 10 fill bits + 16 matches
        gen_n(25);
        check("prelock_25", 32'(bus.locked), 32'd0);
        gen_bit(1'b0, 1'b0);
        check("lock_26", 32'(bus.locked), 32'd1);
        pulse_cnt = 0;
        gen_n(2000);
        check("clean_errcnt", 32'(bus.err_cnt), 32'd0);
        check("clean_locked", 32'(bus.locked), 32'd1);
        check("clean_pulses", 32'(pulse_cnt), 32'd0);

        // Single channel error counts exactly once
        gen_bit(1'b1, 1'b0);
        check("single_pulse",  32'(bus.err_pulse), 32'd1);
        check("single_errcnt", 32'(bus.err_cnt), 32'd1);
        check("single_locked", 32'(bus.locked), 32'd1);
        gen_n(50);
        check("after50_pulses", 32'(pulse_cnt), 32'd1);
        check("after50_errcnt", 32'(bus.err_cnt), 32'd1);
        check("after50_locked", 32'(bus.locked), 32'd1);

        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_errcnt", 32'(bus.err_cnt), 32'd0);

        // Burst of LOSS_CNT errors drops lock, then reacquire
        for (int i = 0; i < 3; i++) gen_bit(1'b1, 1'b0);
        check("burst3_locked", 32'(bus.locked), 32'd1);
        check("burst3_errcnt", 32'(bus.err_cnt), 32'd3);
        gen_bit(1'b1, 1'b0);
        check("burst4_locked", 32'(bus.locked), 32'd0);
        check("burst4_errcnt", 32'(bus.err_cnt), 32'd4);
        gen_n(25);
        check("relock_25", 32'(bus.locked), 32'd0);
        gen_bit(1'b0, 1'b0);
        check("relock_26", 32'(bus.locked), 32'd1);

        // clr_err coincident with a counted mismatch
        gen_bit(1'b1, 1'b1);
        check("clrmis_pulse",  32'(bus.err_pulse), 32'd1);
        check("clrmis_errcnt", 32'(bus.err_cnt), 32'd0);
        gen_bit(1'b1, 1'b0);
        check("post_clr_errcnt", 32'(bus.err_cnt), 32'd1);
        gen_n(5);

        // Resync keeps err_cnt; lock with gapped valid
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("res_locked", 32'(bus.locked), 32'd0);
        check("res_errcnt", 32'(bus.err_cnt), 32'd1);
        pulse_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            gen_bit(1'b0, 1'b0);
            cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        end
        check("gap_prelock", 32'(bus.locked), 32'd0);
        gen_bit(1'b0, 1'b0);
        check("gap_lock", 32'(bus.locked), 32'd1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("gap_pulses", 32'(pulse_cnt), 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("res2_locked", 32'(bus.locked), 32'd0);
        check("res2_errcnt", 32'(bus.err_cnt), 32'd1);

        // All-ones input: lock-up pattern flagged, never locks
        do_reset();
        locked_seen = 1'b0;
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("stuck_9", 32'(bus.stuck), 32'd0);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("stuck_11", 32'(bus.stuck), 32'd1);
        for (int i = 0; i < 89; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("stuck_100", 32'(bus.stuck), 32'd1);
        check("stuck_nolock", 32'(locked_seen), 32'd0);
        check("stuck_errcnt", 32'(bus.err_cnt), 32'd0);

        // Saturation with a 4-bit counter
        do_reset();
        gen_n(26);
        check("sat_lock", 32'(bus4.locked), 32'd1);
        for (int i = 0; i < 20; i++) begin
            gen_bit(1'b1, 1'b0);
            gen_n(9);
        end
        check("sat_errcnt4",  32'(bus4.err_cnt), 32'd15);
        check("sat_errcnt16", 32'(bus.err_cnt), 32'd20);
        check("sat_locked",   32'(bus4.locked), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("sat_clr4",  32'(bus4.err_cnt), 32'd0);
        check("sat_clr16", 32'(bus.err_cnt), 32'd0);

`ifdef LFSR_CHK_FIRST_ERR_EN
        do_reset();
        gen_n(26);
        check("fe_lock", 32'(bus.locked), 32'd1);
        check("fe_vld0", 32'(bus.first_err_vld), 32'd0);
        gen_n(37);
        gen_bit(1'b1, 1'b0);
        check("fe_pos", 32'(bus.first_err_pos), 32'd37);
        check("fe_vld", 32'(bus.first_err_vld), 32'd1);
        gen_n(5);
        gen_bit(1'b1, 1'b0);
        check("fe_pos_hold", 32'(bus.first_err_pos), 32'd37);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("fe_clr_vld", 32'(bus.first_err_vld), 32'd0);
        check("fe_clr_pos", 32'(bus.first_err_pos), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
